// File: rtl/grant_burst_pkg.sv
// rtl/grant_burst_pkg.sv - shared types and constants for grant_burst_mux
package grant_burst_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int DEFAULT_DATA_W    = 8;
    localparam int DEFAULT_BURST_LEN = 4;

    // Remaining-beat counter must hold BURST_LEN itself, hence the +1.
    function automatic int cnt_width(input int burst_len);
        return $clog2(burst_len + 1);
    endfunction

endpackage

// File: rtl/grant_burst_mux_out_reg.sv
// rtl/grant_burst_mux_out_reg.sv - single-entry valid/ready output register
module burst_out_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              space
);

    // A new beat may enter when the slot is empty or is being emptied this edge.
    assign space = !out_valid || out_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            out_data  <= load_data;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/grant_burst_mux.sv
// rtl/grant_burst_mux.sv - grant-owned fixed-length burst mux onto one output stream
module grant_burst_mux
    import grant_burst_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int BURST_LEN = DEFAULT_BURST_LEN
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              gnt_0,
    input  logic              gnt_1,
    input  logic [DATA_W-1:0] src0_data,
    input  logic              src0_valid,
    output logic              src0_ready,
    input  logic [DATA_W-1:0] src1_data,
    input  logic              src1_valid,
    output logic              src1_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              owner,
    output logic              busy,
    output logic              done_0,
    output logic              done_1
);

    localparam int CNT_W = cnt_width(BURST_LEN);

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   cnt;
    logic               space;
    logic               own_ready;
    logic               sel_valid;
    logic [DATA_W-1:0]  sel_data;
    logic               take;
    logic               grant_seen;
    logic               drain_done;

    burst_out_reg #(.DATA_W(DATA_W)) u_out_reg (
        .clock     (clock),
        .reset     (reset),
        .load      (take),
        .load_data (sel_data),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .space     (space)
    );

    assign sel_valid  = owner ? src1_valid : src0_valid;
    assign sel_data   = owner ? src1_data  : src0_data;
    assign own_ready  = (state == OWN) && space;
    assign src0_ready = own_ready && !owner;
    assign src1_ready = own_ready && owner;
    assign take       = own_ready && sel_valid;
    assign grant_seen = (state == IDLE) && (gnt_0 || gnt_1);
    assign drain_done = (state == DRAIN) && out_valid && out_ready;
    assign busy       = (state != IDLE);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (grant_seen) next_state = OWN;
            OWN:     if (take && (cnt == CNT_W'(1))) next_state = DRAIN;
            DRAIN:   if (drain_done) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Requester 0 wins if the arbiter ever presents both grants.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            owner <= 1'b0;
            cnt   <= '0;
        end else if (grant_seen) begin
            owner <= !gnt_0;
            cnt   <= CNT_W'(BURST_LEN);
        end else if (take) begin
            cnt   <= cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            done_0 <= 1'b0;
            done_1 <= 1'b0;
        end else begin
            done_0 <= drain_done && !owner;
            done_1 <= drain_done && owner;
        end
    end

endmodule

// File: tb/tb_grant_burst_mux.sv
// tb/tb_grant_burst_mux.sv - self-checking bench for grant_burst_mux
module tb_grant_burst_mux;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] gnt   = 2'b00;
    logic [7:0] src0_data = 8'h00, src1_data = 8'h00;
    logic       src0_valid = 1'b0, src1_valid = 1'b0;
    logic       src0_ready, src1_ready;
    logic [7:0] out_data;
    logic       out_valid, owner, busy, done_0, done_1;
    logic       out_ready = 1'b0;

    logic [1:0] b_gnt = 2'b00;
    logic [7:0] b_src0_data = 8'h00, b_src1_data = 8'h00;
    logic       b_src0_valid = 1'b0, b_src1_valid = 1'b0;
    logic       b_src0_ready, b_src1_ready;
    logic [7:0] b_out_data;
    logic       b_out_valid, b_owner, b_busy, b_done_0, b_done_1;
    logic       b_out_ready = 1'b0;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    grant_burst_mux #(.DATA_W(8), .BURST_LEN(4)) dut (
        .clock(clock), .reset(reset), .gnt_0(gnt[0]), .gnt_1(gnt[1]),
        .src0_data(src0_data), .src0_valid(src0_valid), .src0_ready(src0_ready),
        .src1_data(src1_data), .src1_valid(src1_valid), .src1_ready(src1_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .owner(owner), .busy(busy), .done_0(done_0), .done_1(done_1)
    );

    grant_burst_mux #(.DATA_W(8), .BURST_LEN(1)) dut1 (
        .clock(clock), .reset(reset), .gnt_0(b_gnt[0]), .gnt_1(b_gnt[1]),
        .src0_data(b_src0_data), .src0_valid(b_src0_valid), .src0_ready(b_src0_ready),
        .src1_data(b_src1_data), .src1_valid(b_src1_valid), .src1_ready(b_src1_ready),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .owner(b_owner), .busy(b_busy), .done_0(b_done_0), .done_1(b_done_1)
    );

    typedef struct {
        logic [1:0]  g;
        logic        s0v;
        logic [7:0]  s0d;
        logic        s1v;
        logic [7:0]  s1d;
        logic        ordy;
        logic [14:0] exp;
    } vec_t;

    vec_t vecs[14];

    // expected packing: {busy, owner, out_valid, src0_ready, src1_ready, done_0, done_1, out_data}
    function automatic vec_t mk(input logic [1:0] g, input logic s0v, input logic [7:0] s0d,
                                input logic s1v, input logic [7:0] s1d, input logic ordy,
                                input logic e_busy, input logic e_owner, input logic e_ov,
                                input logic [7:0] e_od, input logic e_s0r, input logic e_s1r,
                                input logic e_d0, input logic e_d1);
        vec_t v;
        v.g = g; v.s0v = s0v; v.s0d = s0d; v.s1v = s1v; v.s1d = s1d; v.ordy = ordy;
        v.exp = {e_busy, e_owner, e_ov, e_s0r, e_s1r, e_d0, e_d1, e_od};
        return v;
    endfunction

    function automatic logic [14:0] dut_outs();
        return {busy, owner, out_valid, src0_ready, src1_ready, done_0, done_1, out_data};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Runs one BURST_LEN=4 burst on the main DUT, returning at the done cycle.
    task automatic run_burst(input logic [1:0] g_first, input logic [1:0] g_late, input int src,
                             input logic [7:0] base, input int rmode, input string tag);
        int         idx = 0, cyc = 0, bad = 0, other_done = 0;
        bit         done_seen = 0, seen_busy = 0, prev_stall = 0;
        int         beats_at_done = -1;
        logic [7:0] prev_d = 8'h00;
        logic [7:0] got[$];
        while (!done_seen && cyc < 60) begin
            @(negedge clock);
            gnt       = !seen_busy ? g_first : ((idx >= 2) ? g_late : 2'b00);
            out_ready = (rmode == 0) ? 1'b1 : (cyc % 3 == 0);
            if (src == 0) begin
                src0_valid = (idx < 4); src0_data = base + 8'(idx);
                src1_valid = 1'b1;      src1_data = 8'hEE;
            end else begin
                src1_valid = (idx < 4); src1_data = base + 8'(idx);
                src0_valid = 1'b1;      src0_data = 8'hEE;
            end
            #1;
            if (busy) seen_busy = 1;
            if (prev_stall && (!out_valid || out_data !== prev_d)) bad++;
            if (busy && owner !== src[0]) bad++;
            if ((src == 0) ? src1_ready : src0_ready) bad++;
            if (out_valid && out_ready) got.push_back(out_data);
            prev_stall = out_valid && !out_ready;
            prev_d     = out_data;
            if ((src == 0) ? done_1 : done_0) other_done++;
            if ((src == 0) ? done_0 : done_1) begin
                done_seen = 1;
                beats_at_done = got.size();
            end
            if ((src == 0) ? (src0_valid && src0_ready) : (src1_valid && src1_ready)) idx++;
            cyc++;
        end
        check({tag, "_done_seen"}, 32'(done_seen), 32'd1);
        check({tag, "_beats_at_done"}, 32'(beats_at_done), 32'd4);
        check({tag, "_src_accepts"}, 32'(idx), 32'd4);
        check({tag, "_protocol_violations"}, 32'(bad), 32'd0);
        check({tag, "_other_done"}, 32'(other_done), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_beat%0d", tag, i),
                  (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, 32'(base + 8'(i)));
        end
        src0_valid = 1'b0;
        src1_valid = 1'b0;
    endtask

    initial begin
        int d0_cyc, d1_cyc, d0_n, d1_n, stray;
        logic [7:0] b_got[$];

        vecs[0]  = mk(2'b01, 1, 8'h11, 0, 8'h00, 1,  0,0,0,8'h00,0,0,0,0);
        vecs[1]  = mk(2'b00, 1, 8'h11, 0, 8'h00, 1,  1,0,0,8'h00,1,0,0,0);
        vecs[2]  = mk(2'b00, 1, 8'h12, 0, 8'h00, 1,  1,0,1,8'h11,1,0,0,0);
        vecs[3]  = mk(2'b00, 1, 8'h13, 0, 8'h00, 1,  1,0,1,8'h12,1,0,0,0);
        vecs[4]  = mk(2'b00, 1, 8'h14, 0, 8'h00, 1,  1,0,1,8'h13,1,0,0,0);
        vecs[5]  = mk(2'b00, 0, 8'h00, 0, 8'h00, 1,  1,0,1,8'h14,0,0,0,0);
        vecs[6]  = mk(2'b00, 0, 8'h00, 0, 8'h00, 1,  0,0,0,8'h14,0,0,1,0);
        vecs[7]  = mk(2'b11, 1, 8'h21, 1, 8'hA1, 1,  0,0,0,8'h14,0,0,0,0);
        vecs[8]  = mk(2'b11, 1, 8'h21, 1, 8'hA1, 1,  1,0,0,8'h14,1,0,0,0);
        vecs[9]  = mk(2'b11, 1, 8'h22, 1, 8'hA2, 1,  1,0,1,8'h21,1,0,0,0);
        vecs[10] = mk(2'b11, 1, 8'h23, 1, 8'hA3, 1,  1,0,1,8'h22,1,0,0,0);
        vecs[11] = mk(2'b11, 1, 8'h24, 1, 8'hA4, 1,  1,0,1,8'h23,1,0,0,0);
        vecs[12] = mk(2'b00, 0, 8'h00, 0, 8'h00, 1,  1,0,1,8'h24,0,0,0,0);
        vecs[13] = mk(2'b00, 0, 8'h00, 0, 8'h00, 1,  0,0,0,8'h24,0,0,1,0);

        repeat (3) @(negedge clock);
        check("reset_state", 32'(dut_outs()), 32'd0);
        check("reset_state_len1",
              32'({b_busy, b_owner, b_out_valid, b_src0_ready, b_src1_ready, b_done_0, b_done_1, b_out_data}),
              32'd0);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            @(negedge clock);
            gnt = vecs[i].g;
            src0_valid = vecs[i].s0v; src0_data = vecs[i].s0d;
            src1_valid = vecs[i].s1v; src1_data = vecs[i].s1d;
            out_ready  = vecs[i].ordy;
            #1;
            check($sformatf("vec%0d", i), 32'(dut_outs()), 32'(vecs[i].exp));
        end

        run_burst(2'b10, 2'b00, 1, 8'h31, 1, "stall_src1");
        run_burst(2'b01, 2'b10, 0, 8'h41, 0, "switch_src0");
        run_burst(2'b10, 2'b00, 1, 8'h51, 0, "switch_src1");

        @(negedge clock);
        gnt = 2'b10; src1_valid = 1'b1; src1_data = 8'h91; out_ready = 1'b1;
        @(negedge clock);
        gnt = 2'b00;
        @(negedge clock);
        src1_data = 8'h92;
        @(negedge clock);
        src1_data = 8'h93;
        check("pre_reset_busy", 32'({busy, owner, out_valid, out_data}), 32'({1'b1, 1'b1, 1'b1, 8'h92}));
        #1 reset = 1'b1;
        #1 check("mid_burst_reset", 32'(dut_outs()), 32'd0);
        @(negedge clock);
        reset = 1'b0; src1_valid = 1'b0;
        stray = 0;
        repeat (6) begin
            @(negedge clock);
            #1;
            if (done_0 || done_1 || busy || out_valid) stray++;
        end
        check("post_reset_quiet", 32'(stray), 32'd0);
        run_burst(2'b10, 2'b00, 1, 8'h61, 0, "post_reset");

        d0_cyc = -1; d1_cyc = -1; d0_n = 0; d1_n = 0; stray = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            b_gnt = (c == 0) ? 2'b01 : ((c == 3) ? 2'b10 : 2'b00);
            b_src0_valid = 1'b1; b_src0_data = 8'h71;
            b_src1_valid = 1'b1; b_src1_data = 8'h81;
            b_out_ready  = 1'b1;
            #1;
            if (b_out_valid && b_out_ready) b_got.push_back(b_out_data);
            if (b_done_0) begin d0_n++; d0_cyc = c; end
            if (b_done_1) begin d1_n++; d1_cyc = c; end
            if ((c == 4 || c == 5) && b_owner !== 1'b1) stray++;
        end
        check("len1_done0_cycle", 32'(d0_cyc), 32'd3);
        check("len1_done1_cycle", 32'(d1_cyc), 32'd6);
        check("len1_done_counts", 32'({16'(d0_n), 16'(d1_n)}), 32'h0001_0001);
        check("len1_beat_count", 32'(b_got.size()), 32'd2);
        check("len1_beat0", (b_got.size() > 0) ? 32'(b_got[0]) : 32'hFFFF_FFFF, 32'h71);
        check("len1_beat1", (b_got.size() > 1) ? 32'(b_got[1]) : 32'hFFFF_FFFF, 32'h81);
        check("len1_owner1", 32'(stray), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
